// File: rtl/common_dffram_fifo_pkg.sv
// Shared constants and helpers for the DFF-based RAM used by the FIFO.
// Only the storage macro's bit-enable geometry lives here; FIFO pointer
// and flag logic is kept local to the FIFO itself.
package common_dffram_fifo_pkg;

  // Each write-enable bit on the storage covers one lane of this many bits.
  localparam int DFFRAM_BE_GRAIN = 8;

  // Number of write-enable lanes needed to cover a data word.
  // A partial top lane still gets its own enable bit.
  function automatic int dffram_be_width(input int data_width);
    return (data_width + DFFRAM_BE_GRAIN - 1) / DFFRAM_BE_GRAIN;
  endfunction

endpackage

// File: rtl/common_dffram_2a1wb1r.sv
// Flip-flop RAM with one write port (port a, lane write-enables) and one
// asynchronous read port (port b). Array contents are never reset; the
// active-high rst only blocks writes while the owner is held in reset.
module common_dffram_2a1wb1r
  import common_dffram_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 2,
  parameter int DEPTH      = 4,
  parameter int BE_WIDTH   = dffram_be_width(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic [BE_WIDTH-1:0]   wea,
  input  logic [ADDR_WIDTH-1:0] addra,
  input  logic [DATA_WIDTH-1:0] dina,
  input  logic [ADDR_WIDTH-1:0] addrb,
  output logic [DATA_WIDTH-1:0] doutb
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Write port: each data bit is written only when its lane enable is set.
  always_ff @(posedge clk) begin
    if (!rst && ena) begin
      for (int i = 0; i < DATA_WIDTH; i++) begin
        if (wea[i / DFFRAM_BE_GRAIN]) begin
          mem[addra][i] <= dina[i];
        end
      end
    end
  end

  // Read port: combinational, so the word at addrb is visible immediately.
  always_comb begin
    doutb = mem[addrb];
  end

endmodule

// File: rtl/common_dffram_fifo.sv
// Show-ahead synchronous FIFO built on a flip-flop RAM.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high on that side. in_ready is !full and never looks at out_ready,
// so there is no combinational path from consumer to producer. out_valid
// is !empty and out_data is the oldest entry, read straight from storage.
//
// Occupancy comes only from the two registered pointers, each one bit
// wider than the storage address; the extra MSB is the wrap bit that
// tells full apart from empty when the low bits match.
module common_dffram_fifo
  import common_dffram_fifo_pkg::*;
#(
  parameter int FIFO_DATA_WIDTH = 8,
  parameter int FIFO_ADDR_WIDTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [FIFO_DATA_WIDTH-1:0] in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [FIFO_DATA_WIDTH-1:0] out_data,
  input  logic                       out_ready,
  output logic [FIFO_ADDR_WIDTH:0]   count,
  output logic                       full,
  output logic                       empty
);

  localparam int DEPTH    = 1 << FIFO_ADDR_WIDTH;
  localparam int PTR_W    = FIFO_ADDR_WIDTH + 1;
  localparam int BE_WIDTH = dffram_be_width(FIFO_DATA_WIDTH);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  logic [PTR_W-1:0]    wptr;
  logic [PTR_W-1:0]    rptr;
  logic                push;
  logic                pop;
  logic                storage_rst;
  logic [BE_WIDTH-1:0] wea_all;

  // Flags, occupancy and handshake qualifiers, all from the registered pointers.
  always_comb begin
    full      = (wptr[FIFO_ADDR_WIDTH] != rptr[FIFO_ADDR_WIDTH]) &&
                (wptr[FIFO_ADDR_WIDTH-1:0] == rptr[FIFO_ADDR_WIDTH-1:0]);
    empty     = (wptr == rptr);
    count     = wptr - rptr;
    in_ready  = !full;
    out_valid = !empty;
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
  end

  // Pointer update: flush wins over any push or pop in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + PTR_ONE;
      end
      if (pop) begin
        rptr <= rptr + PTR_ONE;
      end
    end
  end

  // Storage takes an active-high reset and always writes full words.
  always_comb begin
    storage_rst = ~reset;
    wea_all     = '1;
  end

  common_dffram_2a1wb1r #(
    .DATA_WIDTH (FIFO_DATA_WIDTH),
    .ADDR_WIDTH (FIFO_ADDR_WIDTH),
    .DEPTH      (DEPTH),
    .BE_WIDTH   (BE_WIDTH)
  ) u_storage (
    .clk   (clk),
    .rst   (storage_rst),
    .ena   (push),
    .wea   (wea_all),
    .addra (wptr[FIFO_ADDR_WIDTH-1:0]),
    .dina  (in_data),
    .addrb (rptr[FIFO_ADDR_WIDTH-1:0]),
    .doutb (out_data)
  );

endmodule

// File: tb/tb_common_dffram_fifo.sv
// Directed bench for common_dffram_fifo (default 8-bit x 4 deep).
// A queue model tracks the FIFO contents from the handshake rules and a
// negedge compare process checks every output against it; directed steps
// add hand-computed literal checks.
module tb_common_dffram_fifo;

  localparam int DW    = 8;
  localparam int AW    = 2;
  localparam int DEPTH = 1 << AW;

  logic          clk;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
  logic [AW:0]   count;
  logic          full;
  logic          empty;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] exp_q[$];

  common_dffram_fifo #(
    .FIFO_DATA_WIDTH (DW),
    .FIFO_ADDR_WIDTH (AW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: act=timeout req=finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  // ---------------- checker ----------------
  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: act=0x%0h req=0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- model ----------------
  // Contents follow the rules directly: a push needs room, a pop needs an
  // entry, flush and reset empty the queue.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      exp_q.delete();
    end else if (flush) begin
      exp_q.delete();
    end else begin
      automatic bit do_push = in_valid && (exp_q.size() < DEPTH);
      automatic bit do_pop  = out_ready && (exp_q.size() > 0);
      if (do_pop)  void'(exp_q.pop_front());
      if (do_push) exp_q.push_back(in_data);
    end
  end

  // Compare every output against the model away from the active edge.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      chk("count",     int'(count),     exp_q.size());
      chk("empty",     int'(empty),     int'(exp_q.size() == 0));
      chk("full",      int'(full),      int'(exp_q.size() == DEPTH));
      chk("in_ready",  int'(in_ready),  int'(exp_q.size() != DEPTH));
      chk("out_valid", int'(out_valid), int'(exp_q.size() != 0));
      if (exp_q.size() > 0) chk("out_data", int'(out_data), int'(exp_q[0]));
    end
  end

  // ---------------- driver ----------------
  task automatic drive(input bit iv, input logic [DW-1:0] d, input bit ordy, input bit fl);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  // Go idle and land on the next negedge for literal checks.
  task automatic settle();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    @(negedge clk);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b1, 1'b0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_count",     int'(count),     0);
    chk("rst_empty",     int'(empty),     1);
    chk("rst_full",      int'(full),      0);
    chk("rst_in_ready",  int'(in_ready),  1);
    chk("rst_out_valid", int'(out_valid), 0);
    @(posedge clk); #1;
    reset = 1'b1;

    // three pushes with no consumer
    drive(1'b1, 8'h11, 1'b0, 1'b0);
    settle();
    chk("lat_out_valid", int'(out_valid), 1);
    chk("lat_out_data",  int'(out_data),  'h11);
    @(posedge clk); #1;
    drive(1'b1, 8'h22, 1'b0, 1'b0);
    drive(1'b1, 8'h33, 1'b0, 1'b0);
    settle();
    chk("p3_count",    int'(count),    3);
    chk("p3_out_data", int'(out_data), 'h11);
    chk("p3_empty",    int'(empty),    0);
    @(posedge clk); #1;
    drain(3);
    settle();
    chk("p3_drained", int'(empty), 1);
    @(posedge clk); #1;

    // fill to depth, overflow attempt, drain in order
    for (int i = 0; i < 4; i++) drive(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0);
    settle();
    chk("fill_full",     int'(full),     1);
    chk("fill_in_ready", int'(in_ready), 0);
    @(posedge clk); #1;
    drive(1'b1, 8'hA4, 1'b0, 1'b0);
    settle();
    chk("ovf_count", int'(count),    4);
    chk("ovf_head",  int'(out_data), 'hA0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(negedge clk);
      chk("fill_pop", int'(out_data), 'hA0 + i);
    end
    @(posedge clk); #1;
    settle();
    chk("fill_empty", int'(empty), 1);
    @(posedge clk); #1;

    // full with push and pop together: pop only, then push next cycle
    for (int i = 0; i < 4; i++) drive(1'b1, 8'h50 + 8'(i), 1'b0, 1'b0);
    drive(1'b1, 8'hB5, 1'b1, 1'b0);
    settle();
    chk("fpp_count", int'(count),    3);
    chk("fpp_head",  int'(out_data), 'h51);
    @(posedge clk); #1;
    drive(1'b1, 8'hB5, 1'b0, 1'b0);
    settle();
    chk("fpp_count2", int'(count), 4);
    @(posedge clk); #1;
    drain(3);
    settle();
    chk("fpp_tail", int'(out_data), 'hB5);
    @(posedge clk); #1;
    drain(1);

    // steady state at count 2 with continuous push+pop
    drive(1'b1, 8'h60, 1'b0, 1'b0);
    drive(1'b1, 8'h61, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      in_valid  = 1'b1;
      in_data   = 8'h62 + 8'(i);
      out_ready = 1'b1;
      @(negedge clk);
      chk("ss_head",  int'(out_data), 'h60 + i);
      chk("ss_count", int'(count),    2);
      @(posedge clk); #1;
    end
    settle();
    chk("ss_after0", int'(out_data), 'h6A);
    @(posedge clk); #1;
    drive(1'b0, '0, 1'b1, 1'b0);
    settle();
    chk("ss_after1", int'(out_data), 'h6B);
    @(posedge clk); #1;
    drain(1);

    // flush overrides a concurrent push
    for (int i = 0; i < 3; i++) drive(1'b1, 8'h70 + 8'(i), 1'b0, 1'b0);
    drive(1'b1, 8'hEE, 1'b0, 1'b1);
    settle();
    chk("fl_count", int'(count), 0);
    chk("fl_empty", int'(empty), 1);
    @(posedge clk); #1;
    drive(1'b1, 8'hC7, 1'b0, 1'b0);
    settle();
    chk("fl_push", int'(out_data), 'hC7);
    chk("fl_cnt1", int'(count),    1);
    @(posedge clk); #1;
    drain(1);

    // asynchronous reset between edges
    drive(1'b1, 8'h80, 1'b0, 1'b0);
    drive(1'b1, 8'h81, 1'b0, 1'b0);
    settle();
    chk("ar_pre", int'(count), 2);
    #2;
    reset = 1'b0;
    #1;
    chk("ar_count",     int'(count),     0);
    chk("ar_out_valid", int'(out_valid), 0);
    @(posedge clk); #1;
    reset = 1'b1;
    drive(1'b1, 8'hD1, 1'b0, 1'b0);
    settle();
    chk("ar_push", int'(out_data), 'hD1);
    chk("ar_cnt1", int'(count),    1);
    @(posedge clk); #1;
    drain(1);
    settle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/common_dffram_fifo.md
COMMON_DFFRAM_FIFO -- requirements
Module: common_dffram_fifo

Interface
REQ-001 The block SHALL have parameter FIFO_DATA_WIDTH, default 8, meaning entry width in bits.
REQ-002 The block SHALL have parameter FIFO_ADDR_WIDTH, default 2, meaning log2 of depth (DEPTH = 2^FIFO_ADDR_WIDTH, minimum 1).
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 flush  input  1  synchronous clear of all entries, active-high.
REQ-006 in_valid  input  1  producer offers in_data this cycle.
REQ-007 in_data  input  FIFO_DATA_WIDTH  entry to push.
REQ-008 in_ready  output  1  FIFO accepts a push this cycle.
REQ-009 out_valid  output  1  out_data holds the oldest entry.
REQ-010 out_data  output  FIFO_DATA_WIDTH  oldest entry, show-ahead.
REQ-011 out_ready  input  1  consumer takes out_data this cycle.
REQ-012 count  output  FIFO_ADDR_WIDTH+1  current occupancy, 0..DEPTH.
REQ-013 full / empty  output  1 each  count==DEPTH / count==0.

Function
REQ-014 Push SHALL occur when in_valid && in_ready; pop SHALL occur when out_valid && out_ready.
REQ-015 in_ready SHALL equal !full and SHALL NOT depend on out_ready (no combinational ready path).
REQ-016 out_valid SHALL equal !empty; out_data SHALL be combinational from storage at the read pointer (zero-latency show-ahead).
REQ-017 Write and read pointers SHALL be FIFO_ADDR_WIDTH+1 bits; low bits index storage, MSB is the wrap bit.
REQ-018 full SHALL be (wptr MSB != rptr MSB) && low bits equal; empty SHALL be wptr == rptr.
REQ-019 count SHALL equal wptr - rptr modulo 2^(FIFO_ADDR_WIDTH+1), registered-pointer derived, no separate counter.
REQ-020 Each push SHALL write in_data at wptr low bits with all bit-enables set and increment wptr by 1, wrapping naturally.
REQ-021 Each pop SHALL increment rptr by 1, wrapping naturally.
REQ-022 Latency: a pushed entry SHALL be visible at out_data with out_valid=1 on the cycle after the push edge.
REQ-023 Simultaneous push and pop with 0<count<DEPTH SHALL leave count unchanged and advance both pointers.
REQ-024 When full, a simultaneous pop SHALL complete but no push SHALL occur that cycle (in_ready=0).
REQ-025 When empty, in_valid SHALL NOT bypass to out_data; push completes, out_valid rises next cycle.
REQ-026 flush SHALL set wptr=rptr=0 at the next edge, overriding any push or pop in the same cycle.
REQ-027 Storage contents SHALL be don't-care after reset or flush; only pointers define state.

Reset
REQ-028 On reset low, wptr and rptr SHALL clear to 0 asynchronously: count=0, empty=1, full=0, in_ready=1, out_valid=0.
REQ-029 Reset asserted mid-operation SHALL discard all entries; the first push after release SHALL land at index 0.
REQ-030 The storage sub-module reset input SHALL be driven with the inverted active-high form of reset.

Structure
REQ-031 Storage SHALL be one instance of common_dffram_2a1wb1r: addra=wptr low bits, ena=push, wea all-ones, dina=in_data, addrb=rptr low bits, doutb=out_data.
REQ-032 Pointer/flag logic SHALL be local; no shared package typedefs; DEPTH SHALL be a localparam.

Verification
REQ-033 Reset, then push 0x11,0x22,0x33 one per cycle, out_ready=0 -> count=3, out_data=0x11, empty=0.
REQ-034 Depth 4: push 0xA0..0xA3 -> full=1, in_ready=0; 5th push 0xA4 ignored; pop four -> 0xA0,0xA1,0xA2,0xA3, then empty=1.
REQ-035 Full, in_valid=1 data 0xB5 and out_ready=1 -> pop of oldest, count=3; next cycle push of 0xB5 accepted, count=4.
REQ-036 Count=2, continuous push+pop for 10 cycles with incrementing data -> count stays 2, pointers wrap, output order strictly FIFO.
REQ-037 Count=3, assert flush with in_valid=1 -> next cycle count=0, empty=1; following push 0xC7 -> out_data=0xC7.
REQ-038 Count=2, drop reset low between edges -> immediately count=0, out_valid=0; after release push 0xD1 -> out_data=0xD1.
